// File: rtl/myproject_mul_pipe_rnd.sv
// Pipelined mixed-sign fixed-point multiplier with in-block requantise
// (round-half-up, arithmetic shift, saturate or wrap) and a stallable valid pipe.
module myproject_mul_pipe_rnd #(
    parameter int ID          = 1,
    parameter int NUM_STAGE   = 3,
    parameter int din0_WIDTH  = 25,
    parameter int din1_WIDTH  = 19,
    parameter int din0_SIGNED = 0,
    parameter int din1_SIGNED = 1,
    parameter int SHIFT       = 18,
    parameter int ROUND       = 1,
    parameter int SATURATE    = 1,
    parameter int dout_WIDTH  = 26
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ce,
    input  logic                         din_vld,
    input  logic [din0_WIDTH-1:0]        din0,
    input  logic [din1_WIDTH-1:0]        din1,
    output logic signed [dout_WIDTH-1:0] dout,
    output logic                         dout_vld,
    output logic                         dout_ovf
);

    localparam int unsigned W0      = din0_WIDTH;
    localparam int unsigned W1      = din1_WIDTH;
    localparam int unsigned DW      = dout_WIDTH;
    localparam int unsigned PW      = W0 + W1 + 1;
    localparam int unsigned CW      = ((PW + 1 > DW) ? PW + 1 : DW) + 1;
    localparam int unsigned PDLY    = (NUM_STAGE > 2) ? NUM_STAGE - 2 : 0;
    localparam int unsigned RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [PW:0]   RND_ADD = (ROUND != 0 && SHIFT > 0) ?
                                               ((PW + 1)'(1) << RND_POS) : '0;
    localparam logic signed [CW-1:0] MAX_V   = (CW'(1) << (DW - 1)) - CW'(1);
    localparam logic signed [CW-1:0] MIN_V   = -(CW'(1) << (DW - 1));

    // Reject out-of-range configurations at elaboration.
    if (ID < 0 || NUM_STAGE < 1 || NUM_STAGE > 4 || SHIFT < 0 ||
        SHIFT > din0_WIDTH + din1_WIDTH - 1) begin : g_bad_param
        $error("myproject_mul_pipe_rnd: illegal parameter combination");
    end

    logic [W0-1:0]          op0;
    logic [W1-1:0]          op1;
    logic signed [PW-1:0]   ext0_c;
    logic signed [PW-1:0]   ext1_c;
    logic signed [PW-1:0]   prod_c;
    logic signed [PW-1:0]   prod_fin;
    logic signed [PW:0]     rnd_c;
    logic signed [PW:0]     shf_c;
    logic signed [CW-1:0]   q_c;
    logic                   ovf_c;
    logic [DW-1:0]          res_c;
    logic [NUM_STAGE-1:0]   vld_sr;

    // Operand register stage; absent when the whole path sits before one register.
    if (NUM_STAGE > 1) begin : g_op_reg
        logic [W0-1:0] op0_q;
        logic [W1-1:0] op1_q;
        always_ff @(posedge clk) begin
            if (ce) begin
                op0_q <= din0;
                op1_q <= din1;
            end
        end
        assign op0 = op0_q;
        assign op1 = op1_q;
    end else begin : g_op_pass
        assign op0 = din0;
        assign op1 = din1;
    end

    // Extending to PW bits keeps the product exact for every sign mix.
    always_comb begin
        ext0_c = (din0_SIGNED != 0) ? PW'($signed(op0)) : PW'(op0);
        ext1_c = (din1_SIGNED != 0) ? PW'($signed(op1)) : PW'(op1);
        prod_c = ext0_c * ext1_c;
    end

    if (PDLY > 0) begin : g_prod_reg
        logic signed [PW-1:0] pipe [PDLY];
        always_ff @(posedge clk) begin
            if (ce) begin
                pipe[0] <= prod_c;
                for (int unsigned i = 1; i < PDLY; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
        assign prod_fin = pipe[PDLY-1];
    end else begin : g_prod_pass
        assign prod_fin = prod_c;
    end

    // Round half up, floor shift, then clamp or wrap into the output range.
    always_comb begin
        rnd_c = (PW + 1)'(prod_fin) + RND_ADD;
        shf_c = rnd_c >>> SHIFT;
        q_c   = CW'(shf_c);
        ovf_c = (q_c > MAX_V) || (q_c < MIN_V);
        res_c = q_c[DW-1:0];
        if (ovf_c && SATURATE != 0) begin
            res_c = (q_c > MAX_V) ? MAX_V[DW-1:0] : MIN_V[DW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout     <= '0;
            dout_ovf <= 1'b0;
            vld_sr   <= '0;
        end else if (ce) begin
            dout     <= res_c;
            dout_ovf <= ovf_c;
            vld_sr   <= (vld_sr << 1) | NUM_STAGE'(din_vld);
        end
    end

    assign dout_vld = vld_sr[NUM_STAGE-1];

endmodule

// File: tb/tb_myproject_mul_pipe_rnd.sv
// Randomised scoreboard bench: four differently configured multipliers share one
// stimulus stream; expected results and due cycles come from plain integer arithmetic.
module tb_myproject_mul_pipe_rnd;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        din_vld;
    logic [24:0] din0;
    logic [18:0] din1;

    logic signed [25:0] dout0;
    logic signed [15:0] dout1;
    logic signed [15:0] dout2;
    logic signed [25:0] dout3;
    logic [3:0]         vld_x;
    logic [3:0]         ovf_x;

    always #5 clk = ~clk;

    myproject_mul_pipe_rnd #(.ID(0), .NUM_STAGE(3), .din0_WIDTH(25), .din1_WIDTH(19),
        .din0_SIGNED(0), .din1_SIGNED(1), .SHIFT(18), .ROUND(1), .SATURATE(1), .dout_WIDTH(26))
    u_d0 (.clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
          .dout(dout0), .dout_vld(vld_x[0]), .dout_ovf(ovf_x[0]));

    myproject_mul_pipe_rnd #(.ID(1), .NUM_STAGE(1), .din0_WIDTH(25), .din1_WIDTH(19),
        .din0_SIGNED(1), .din1_SIGNED(0), .SHIFT(18), .ROUND(0), .SATURATE(1), .dout_WIDTH(16))
    u_d1 (.clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
          .dout(dout1), .dout_vld(vld_x[1]), .dout_ovf(ovf_x[1]));

    myproject_mul_pipe_rnd #(.ID(2), .NUM_STAGE(4), .din0_WIDTH(25), .din1_WIDTH(19),
        .din0_SIGNED(0), .din1_SIGNED(1), .SHIFT(18), .ROUND(1), .SATURATE(0), .dout_WIDTH(16))
    u_d2 (.clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
          .dout(dout2), .dout_vld(vld_x[2]), .dout_ovf(ovf_x[2]));

    myproject_mul_pipe_rnd #(.ID(3), .NUM_STAGE(2), .din0_WIDTH(25), .din1_WIDTH(19),
        .din0_SIGNED(1), .din1_SIGNED(1), .SHIFT(0), .ROUND(1), .SATURATE(0), .dout_WIDTH(26))
    u_d3 (.clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld), .din0(din0), .din1(din1),
          .dout(dout3), .dout_vld(vld_x[3]), .dout_ovf(ovf_x[3]));

    typedef struct {
        logic [3:0][63:0] res;
        logic [3:0]       ovf;
        longint           en_idx;
    } acc_t;

    acc_t        acc_q[$];
    acc_t        ent;
    longint      en_cnt = 0;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          rd       [4];
    bit          last_v   [4];
    logic [63:0] last_res [4];
    bit          last_ovf [4];

    function automatic int ns(input int d);
        case (d)
            0: return 3;
            1: return 1;
            2: return 4;
            default: return 2;
        endcase
    endfunction

    function automatic logic [63:0] get_dout(input int d);
        case (d)
            0: return 64'(dout0);
            1: return 64'(dout1);
            2: return 64'(dout2);
            default: return 64'(dout3);
        endcase
    endfunction

    // Reference: exact integer product, add half-LSB, floor divide, then range rule.
    function automatic void model(input int d, input logic [24:0] a, input logic [18:0] b,
                                  output logic [63:0] res, output bit ovf);
        bit s0, s1, rnd, sat;
        int sh, dw;
        longint av, bv, p, q, mx, mn, r;
        case (d)
            0: begin s0 = 0; s1 = 1; sh = 18; rnd = 1; sat = 1; dw = 26; end
            1: begin s0 = 1; s1 = 0; sh = 18; rnd = 0; sat = 1; dw = 16; end
            2: begin s0 = 0; s1 = 1; sh = 18; rnd = 1; sat = 0; dw = 16; end
            default: begin s0 = 1; s1 = 1; sh = 0; rnd = 1; sat = 0; dw = 26; end
        endcase
        av = longint'(a);
        bv = longint'(b);
        if (s0 && a[24]) av = av - (longint'(1) <<< 25);
        if (s1 && b[18]) bv = bv - (longint'(1) <<< 19);
        p = av * bv;
        if (rnd && sh > 0) p = p + (longint'(1) <<< (sh - 1));
        q  = p >>> sh;
        mx = (longint'(1) <<< (dw - 1)) - 1;
        mn = -(longint'(1) <<< (dw - 1));
        ovf = (q > mx) || (q < mn);
        if (!ovf) r = q;
        else if (sat) r = (q > mx) ? mx : mn;
        else begin
            r = q & ((longint'(1) <<< dw) - 1);
            if (r > mx) r = r - (longint'(1) <<< dw);
        end
        res = r;
    endfunction

    task automatic chk(input string nm, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d t=%0t: got %0d, expected %0d",
                      nm, d, $time, $signed(act), $signed(exp));
    endtask

    // Scoreboard push: every accepted sample gets its expected result for each DUT.
    always @(posedge clk) begin
        if (reset !== 1'b1 && ce === 1'b1) begin
            en_cnt++;
            if (din_vld === 1'b1) begin
                for (int d = 0; d < 4; d++) begin
                    logic [63:0] r;
                    bit          o;
                    model(d, din0, din1, r, o);
                    ent.res[d] = r;
                    ent.ovf[d] = o;
                end
                ent.en_idx = en_cnt;
                acc_q.push_back(ent);
            end
        end
    end

    // Monitor: after each edge, compare outputs with the head of each DUT's stream.
    initial begin
        bit rst_s, ce_s, exp_v;
        for (int d = 0; d < 4; d++) begin
            rd[d] = 0; last_v[d] = 0; last_res[d] = '0; last_ovf[d] = 0;
        end
        forever begin
            @(posedge clk);
            rst_s = (reset === 1'b1);
            ce_s  = (ce === 1'b1);
            #1;
            for (int d = 0; d < 4; d++) begin
                if (rst_s) begin
                    chk("reset_vld", d, 64'(vld_x[d]), 64'd0);
                    chk("reset_dout", d, get_dout(d), 64'd0);
                    chk("reset_ovf", d, 64'(ovf_x[d]), 64'd0);
                    rd[d] = acc_q.size();
                    last_v[d] = 0;
                end else if (ce_s) begin
                    exp_v = (rd[d] < acc_q.size()) &&
                            (acc_q[rd[d]].en_idx + longint'(ns(d)) - 1 == en_cnt);
                    chk("vld", d, 64'(vld_x[d]), 64'(exp_v));
                    if (exp_v) begin
                        chk("dout", d, get_dout(d), acc_q[rd[d]].res[d]);
                        chk("ovf", d, 64'(ovf_x[d]), 64'(acc_q[rd[d]].ovf[d]));
                        last_res[d] = acc_q[rd[d]].res[d];
                        last_ovf[d] = acc_q[rd[d]].ovf[d];
                        rd[d]++;
                    end
                    last_v[d] = exp_v;
                end else begin
                    chk("stall_vld", d, 64'(vld_x[d]), 64'(last_v[d]));
                    if (last_v[d]) begin
                        chk("stall_dout", d, get_dout(d), last_res[d]);
                        chk("stall_ovf", d, 64'(ovf_x[d]), 64'(last_ovf[d]));
                    end
                end
            end
        end
    end

    task automatic step(input bit r, input bit c, input bit v,
                        input logic [24:0] a, input logic [18:0] b);
        reset = r; ce = c; din_vld = v; din0 = a; din1 = b;
        @(negedge clk);
    endtask

    function automatic logic [24:0] rand_a();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 25'h1FFFFFF;
            2: return 25'h1000000;
            3: return 25'h0FFFFFF;
            default: return 25'($urandom);
        endcase
    endfunction

    function automatic logic [18:0] rand_b();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 19'h7FFFF;
            2: return 19'h40000;
            3: return 19'h3FFFF;
            default: return 19'($urandom);
        endcase
    endfunction

    initial begin
        repeat (3) step(1, 1, 0, '0, '0);
        // Directed: unit scale, round half cases, saturation, corner operands.
        step(0, 1, 1, 25'(1 << 18), 19'd5);
        step(0, 1, 0, '0, '0);
        step(0, 1, 0, '0, '0);
        step(0, 1, 1, 25'd3, 19'(1 << 17));
        step(0, 1, 1, 25'd3, 19'(-(1 << 17)));
        step(0, 1, 1, 25'(1 << 24), 19'(1 << 10));
        step(0, 1, 1, 25'(1 << 24), 19'(-1024));
        step(0, 1, 1, 25'h1FFFFFF, 19'h7FFFF);
        step(0, 1, 1, 25'h1000000, 19'h40000);
        step(0, 1, 1, 25'h0FFFFFF, 19'h3FFFF);
        repeat (5) step(0, 1, 0, '0, '0);
        // Back-to-back stream with a three-cycle stall in the middle.
        for (int i = 1; i <= 8; i++) begin
            if (i == 5) repeat (3) step(0, 0, 1, rand_a(), rand_b());
            step(0, 1, 1, 25'(1 << 18), 19'(i));
        end
        repeat (5) step(0, 1, 0, '0, '0);
        // Reset with two samples in flight and ce low at the reset edge.
        step(0, 1, 1, 25'(1 << 18), 19'd7);
        step(0, 1, 1, 25'(1 << 18), 19'd9);
        step(1, 0, 1, rand_a(), rand_b());
        repeat (6) step(0, 1, 0, '0, '0);
        // Random traffic with random stalls and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 3) != 0, rand_a(), rand_b());
        end
        repeat (10) step(0, 1, 0, '0, '0);
        for (int d = 0; d < 4; d++) chk("drained", d, 64'(rd[d]), 64'(acc_q.size()));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
